// File: rtl/ip_full_arbiter.sv
// Round-robin arbiter/sequencer sharing one ip_full datapath between two requesters.
// Optional watchdog on the WAIT state: define IP_FULL_ARB_TIMEOUT_EN.
module ip_full_arbiter #(
    parameter int A_W     = 8,
    parameter int B_W     = 4,
    parameter int TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [A_W-1:0] req0_a,
    input  logic [B_W-1:0] req0_b,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [A_W-1:0] req1_a,
    input  logic [B_W-1:0] req1_b,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [A_W-1:0] rsp_a,
    output logic [B_W-1:0] rsp_b,
    output logic           rsp_err,
    output logic [A_W-1:0] ip_din_a,
    output logic [B_W-1:0] ip_din_b,
    input  logic [A_W-1:0] ip_dout_a,
    input  logic [B_W-1:0] ip_dout_b,
    input  logic           ip_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state;
    logic   last_grant;
    logic   grant;
    logic   any_valid;
    logic   accept;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("TIMEOUT out of range 1..255");
    end

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        grant     = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        accept    = (state == S_IDLE) && any_valid;
    end

    assign req0_ready = accept && !grant;
    assign req1_ready = accept && grant;

`ifdef IP_FULL_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);
    logic [7:0] wait_cnt;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            ip_din_a   <= '0;
            ip_din_b   <= '0;
            rsp_valid  <= 1'b0;
            rsp_a      <= '0;
            rsp_b      <= '0;
            rsp_id     <= 1'b0;
`ifdef IP_FULL_ARB_TIMEOUT_EN
            wait_cnt   <= '0;
            rsp_err    <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (any_valid) begin
                        ip_din_a   <= grant ? req1_a : req0_a;
                        ip_din_b   <= grant ? req1_b : req0_b;
                        rsp_id     <= grant;
                        last_grant <= grant;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
`ifdef IP_FULL_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (ip_ready) begin
                        rsp_a     <= ip_dout_a;
                        rsp_b     <= ip_dout_b;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
`ifdef IP_FULL_ARB_TIMEOUT_EN
                        rsp_err   <= 1'b0;
                    end else if (wait_cnt >= TO_LIM) begin
                        rsp_a     <= '0;
                        rsp_b     <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else if (wait_cnt != 8'hFF) begin
                        wait_cnt  <= wait_cnt + 8'd1;
`endif
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ip_full_arbiter.md
# ip_full_arbiter

Round-robin arbiter and sequencer that shares one `ip_full` datapath instance between two requesters. It sits between two request/response clients and the `ip_full` instance, in place of direct wiring. It accepts one operand pair (`a`, `b`) at a time and drives it onto the IP. It waits for the IP's `ready`, captures `dout_a`/`dout_b`, and returns them tagged with the requester ID. An optional watchdog aborts transactions whose `ready` never arrives.

## Interface
Parameters:
- `A_W`, default 8: width of operand/result A.
- `B_W`, default 4: width of operand/result B.
- `TIMEOUT`, default 15: WAIT-state cycle limit. Range 1..255. Used only with the macro.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`  in  1  requester 0 has an operand pair.
- `req0_ready`  out  1  requester 0 accepted this cycle.
- `req0_a`  in  A_W  requester 0 operand A.
- `req0_b`  in  B_W  requester 0 operand B.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`: same as requester 0, for requester 1.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_id`  out  1  requester that issued the transaction.
- `rsp_a`  out  A_W  captured `dout_a`.
- `rsp_b`  out  B_W  captured `dout_b`.
- `rsp_err`  out  1  transaction timed out.
- `ip_din_a`  out  A_W  to IP `din_a`.
- `ip_din_b`  out  B_W  to IP `din_b`.
- `ip_dout_a`  in  A_W  from IP `dout_a`.
- `ip_dout_b`  in  B_W  from IP `dout_b`.
- `ip_ready`  in  1  from IP `ready`, level-sensitive.

## Operation
FSM states and transitions:
- **IDLE**: stay here while no valid request is present. If any `reqN_valid` is high, grant one requester and go to ISSUE.
- **ISSUE**: one-cycle settle; always go to WAIT and clear the wait counter.
- **WAIT**: if `ip_ready`=1, capture `ip_dout_a`/`ip_dout_b` and go to RESP. Otherwise increment the counter.
- **RESP**: hold `rsp_valid`=1 until `rsp_valid && rsp_ready`, then go to IDLE.

Arbitration and handshake rules:
- Arbitration is round-robin using a `last_grant` register, reset value 1, so requester 0 wins the first tie.
  - If both requesters are valid, grant the one that is not `last_grant`.
  - If only one is valid, grant it.
  - `last_grant` updates on each accept.
- `reqN_ready` is combinational: it is 1 only in IDLE, for the granted requester, when its `reqN_valid`=1. At most one `reqN_ready` is high per cycle.
- On accept, `reqN_a`/`reqN_b` are registered into the operand registers and `rsp_id` is set to N.
- `ip_din_a`/`ip_din_b` are driven from the operand registers. They stay stable from ISSUE through RESP and hold their value in IDLE.
- `ip_ready` is ignored outside WAIT.
- `rsp_a`, `rsp_b`, `rsp_id` and `rsp_err` are stable while `rsp_valid`=1.

Reset values (all outputs and registers):
- `rsp_valid`=0, `rsp_a`=0, `rsp_b`=0, `rsp_id`=0, `rsp_err`=0.
- `ip_din_a`=0, `ip_din_b`=0, `req0_ready`=0, `req1_ready`=0.
- FSM in IDLE, wait counter 0.

Boundary conditions:
- A requester that drops `valid` before being granted loses nothing; no state changes.
- A request that arrives during a busy period waits. It is granted in the IDLE cycle after the RESP handshake.
- Asserting `rst_n` mid-transaction aborts immediately. The pending response is discarded and is never delivered.
- The wait counter is 8 bits wide and saturates; it never wraps.

## Timing
- **Cycle 0**: IDLE, handshake on `reqN_valid && reqN_ready`.
- **Cycle 1**: ISSUE; `ip_din_*` already shows the new operands.
- **Cycle 2**: WAIT. If `ip_ready`=1, the result is captured at the end of this cycle.
- **Cycle 3**: `rsp_valid`=1. Minimum latency from accept to `rsp_valid` is 3 cycles. Each additional WAIT cycle adds 1.
- **Throughput**: a new accept can occur no earlier than the cycle after the RESP handshake. Back-to-back throughput is at best 1 transaction per 4 cycles.

## Configuration
- Macro: `IP_FULL_ARB_TIMEOUT_EN`.
- **Defined**:
  - After TIMEOUT consecutive WAIT cycles with `ip_ready`=0, go to RESP with `rsp_err`=1 and `rsp_a`=`rsp_b`=0.
  - If `ip_ready`=1 on the same cycle the limit is reached, the result wins and `rsp_err`=0.
- **Undefined**:
  - No counter logic; WAIT persists indefinitely.
  - `rsp_err` is tied to 0.
  - The port list is unchanged.

## Test plan
- **Single request, immediate ready:** reset; `req0_valid` with a=0xA5, b=0x3; `ip_ready` held 1; IP model echoes its inputs. Required: `req0_ready` pulses in cycle 0; `ip_din_a`=0xA5 in cycle 1; `rsp_valid` in cycle 3 with id=0, a=0xA5, b=0x3, err=0.
- **Simultaneous requests:** req0 a=0x11 and req1 a=0x22 both valid from reset. Required grant order: req0, then req1, then req0 while both stay valid; `rsp_id` sequence 0,1,0.
- **Response backpressure:** `rsp_ready`=0 for 5 cycles. Required: `rsp_valid` and all `rsp_*` values held constant; no new `reqN_ready` until one cycle after `rsp_ready`=1.
- **Slow IP:** `ip_ready` goes high 6 cycles after ISSUE. Required: `rsp_valid` appears at cycle 8; `ip_din_*` stable throughout.
- **Timeout (macro defined, TIMEOUT=4):** `ip_ready` held 0. Required: `rsp_valid` with err=1, a=0, b=0 at cycle 7. Without the macro: no response within 100 cycles.
- **Reset mid-WAIT:** drive `rst_n` low during WAIT. Required: all outputs return to their reset values asynchronously; no response is delivered after reset deasserts.
